// File: rtl/sprite_scheduler.sv
// Sprite scheduler: picks the highest-priority sprite covering each active
// pixel, addresses the shared sprite ROM and composites over the background.
// Sprite positions are double-buffered and committed at frame start.
module sprite_scheduler #(
  parameter int          NUM_SPRITES = 4,
  parameter int          COORD_W     = 10,
  parameter logic [23:0] TRANSPARENT = 24'h000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               pixel_valid,
  input  logic               frame_start,
  input  logic [23:0]        bg_color,
  input  logic               wr_en,
  input  logic [1:0]         wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_enable,
  output logic [7:0]         rom_addr,
  input  logic [23:0]        rom_data,
  output logic [23:0]        pix_out,
  output logic               pix_valid_out,
  output logic               hit_out,
  output logic [1:0]         hit_idx,
  output logic               collision_out
);

  // Shadow (CPU-written) and active (displayed) sprite registers
  logic [COORD_W-1:0] shadow_x_q  [NUM_SPRITES];
  logic [COORD_W-1:0] shadow_y_q  [NUM_SPRITES];
  logic               shadow_en_q [NUM_SPRITES];
  logic [COORD_W-1:0] active_x_q  [NUM_SPRITES];
  logic [COORD_W-1:0] active_y_q  [NUM_SPRITES];
  logic               active_en_q [NUM_SPRITES];

  // Per-slot coverage and texel address
  logic [COORD_W:0]   dx         [NUM_SPRITES];
  logic [COORD_W:0]   dy         [NUM_SPRITES];
  logic [7:0]         slot_addr  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] covered;

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
    localparam logic [1:0] SLOT = 2'(gi);

    // Shadow write from the CPU side; whole-set commit on frame_start
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow_x_q[gi]  <= '0;
        shadow_y_q[gi]  <= '0;
        shadow_en_q[gi] <= 1'b0;
        active_x_q[gi]  <= '0;
        active_y_q[gi]  <= '0;
        active_en_q[gi] <= 1'b0;
      end else begin
        if (wr_en && (wr_idx == SLOT)) begin
          shadow_x_q[gi]  <= wr_x;
          shadow_y_q[gi]  <= wr_y;
          shadow_en_q[gi] <= wr_enable;
        end
        // Commit samples the pre-write shadow, so a same-cycle write waits
        // for the following frame_start.
        if (frame_start) begin
          active_x_q[gi]  <= shadow_x_q[gi];
          active_y_q[gi]  <= shadow_y_q[gi];
          active_en_q[gi] <= shadow_en_q[gi];
        end
      end
    end

    // Differences carry an extra bit so a pixel left of / above the sprite
    // reads as negative rather than wrapping into range.
    assign dx[gi] = {1'b0, pixel_x} - {1'b0, active_x_q[gi]};
    assign dy[gi] = {1'b0, pixel_y} - {1'b0, active_y_q[gi]};
    assign slot_addr[gi] = {dy[gi][3:0], dx[gi][3:0]};
    assign covered[gi] = active_en_q[gi] && pixel_valid &&
                         (dx[gi][COORD_W:4] == '0) && (dy[gi][COORD_W:4] == '0);
  end

  // Priority select (lowest index wins) and overlap detection
  logic       any_hit;
  logic [1:0] sel_idx;
  logic       overlap_now;
  logic       seen;
  always_comb begin
    any_hit     = 1'b0;
    sel_idx     = 2'd0;
    overlap_now = 1'b0;
    seen        = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (covered[i]) begin
        if (seen) overlap_now = 1'b1;
        else      sel_idx = 2'(i);
        seen    = 1'b1;
        any_hit = 1'b1;
      end
    end
  end

  // Stage 1: ROM address and pipeline sideband
  logic        s1_hit_q, s1_valid_q;
  logic [1:0]  s1_idx_q;
  logic [23:0] s1_bg_q;
  logic [7:0]  rom_addr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr_q <= 8'd0;
      s1_hit_q   <= 1'b0;
      s1_idx_q   <= 2'd0;
      s1_bg_q    <= 24'd0;
      s1_valid_q <= 1'b0;
    end else begin
      if (any_hit) rom_addr_q <= slot_addr[sel_idx];
      s1_hit_q   <= any_hit;
      s1_idx_q   <= sel_idx;
      s1_bg_q    <= bg_color;
      s1_valid_q <= pixel_valid;
    end
  end

  // Stage 2: composite the texel over the background, blank outside video
  logic        opaque;
  logic [23:0] pix_q;
  logic        hit_q, pvo_q;
  logic [1:0]  hit_idx_q;
  assign opaque = s1_hit_q && (rom_data != TRANSPARENT);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q     <= 24'd0;
      hit_q     <= 1'b0;
      hit_idx_q <= 2'd0;
      pvo_q     <= 1'b0;
    end else begin
      pix_q     <= !s1_valid_q ? 24'h000000 : (opaque ? rom_data : s1_bg_q);
      hit_q     <= opaque;
      hit_idx_q <= opaque ? s1_idx_q : 2'd0;
      pvo_q     <= s1_valid_q;
    end
  end

  // Per-frame sticky overlap flag, published at frame_start
  logic sticky_q, collision_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q    <= 1'b0;
      collision_q <= 1'b0;
    end else if (frame_start) begin
      collision_q <= sticky_q;
      sticky_q    <= overlap_now;
    end else begin
      sticky_q    <= sticky_q | overlap_now;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign pix_out       = pix_q;
  assign pix_valid_out = pvo_q;
  assign hit_out       = hit_q;
  assign hit_idx       = hit_idx_q;
  assign collision_out = collision_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a small behavioural sprite ROM.
module tb_sprite_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid, frame_start;
  logic [23:0] bg_color;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [9:0]  wr_x, wr_y;
  logic        wr_enable;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [23:0] pix_out;
  logic        pix_valid_out, hit_out, collision_out;
  logic [1:0]  hit_idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Texel 0 is transparent, every other texel is red
  assign rom_data = (rom_addr == 8'd0) ? 24'h000000 : 24'hFF0000;

  sprite_scheduler dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .bg_color(bg_color),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_enable(wr_enable),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_out(pix_out),
    .pix_valid_out(pix_valid_out), .hit_out(hit_out), .hit_idx(hit_idx),
    .collision_out(collision_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                            input logic en, input logic with_fs);
    wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_enable = en;
    frame_start = with_fs;
    step();
    wr_en = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Present one pixel for one cycle; afterwards stage 1 is visible
  task automatic present(input logic [9:0] x, input logic [9:0] y, input logic [23:0] bg);
    pixel_x = x; pixel_y = y; bg_color = bg; pixel_valid = 1'b1;
    step();
    pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pixel_x = 0; pixel_y = 0; pixel_valid = 0; frame_start = 0;
    bg_color = 0; wr_en = 0; wr_idx = 0; wr_x = 0; wr_y = 0; wr_enable = 0;
    step(); step();
    n_cmp++;
    if ({rom_addr, pix_out, pix_valid_out, hit_out, hit_idx, collision_out} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_outputs got addr=%0d pix=%h pvo=%b hit=%b idx=%0d col=%b want all 0",
               rom_addr, pix_out, pix_valid_out, hit_out, hit_idx, collision_out);
    end
    reset = 1'b0;
    step();
    $display("reset: outputs cleared");
  endtask

  task automatic test_basic_hit();
    write_slot(2'd0, 10'd100, 10'd50, 1'b1, 1'b0);
    pulse_fs();
    present(10'd107, 10'd55, 24'h0000FF);
    n_cmp++;
    if (rom_addr !== 8'd87) begin
      n_err++; $display("FAIL basic_addr got %0d want 87", rom_addr);
    end
    step();
    n_cmp++;
    if ({pix_out, hit_out, hit_idx, pix_valid_out} !== {24'hFF0000, 1'b1, 2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL basic_pix got pix=%h hit=%b idx=%0d pvo=%b want FF0000 1 0 1",
               pix_out, hit_out, hit_idx, pix_valid_out);
    end
    step();
    n_cmp++;
    if ({pix_out, pix_valid_out} !== {24'h000000, 1'b0}) begin
      n_err++; $display("FAIL blanking got pix=%h pvo=%b want 000000 0", pix_out, pix_valid_out);
    end
    $display("basic: pixel (107,55) addr=%0d pix=%h", rom_addr, pix_out);
  endtask

  task automatic test_transparent_and_edges();
    present(10'd100, 10'd50, 24'h0000FF);
    n_cmp++;
    if (rom_addr !== 8'd0) begin
      n_err++; $display("FAIL transp_addr got %0d want 0", rom_addr);
    end
    step();
    n_cmp++;
    if ({pix_out, hit_out, hit_idx} !== {24'h0000FF, 1'b0, 2'd0}) begin
      n_err++; $display("FAIL transp_pix got pix=%h hit=%b idx=%0d want 0000FF 0 0", pix_out, hit_out, hit_idx);
    end
    // Bottom-right texel of the sprite
    present(10'd115, 10'd65, 24'h0000FF);
    n_cmp++;
    if (rom_addr !== 8'd255) begin
      n_err++; $display("FAIL corner_addr got %0d want 255", rom_addr);
    end
    step();
    // Just left and just right of the sprite: not covered, address held
    present(10'd99, 10'd50, 24'h123456);
    n_cmp++;
    if (rom_addr !== 8'd255) begin
      n_err++; $display("FAIL left_hold_addr got %0d want 255", rom_addr);
    end
    step();
    n_cmp++;
    if ({pix_out, hit_out} !== {24'h123456, 1'b0}) begin
      n_err++; $display("FAIL left_edge got pix=%h hit=%b want 123456 0", pix_out, hit_out);
    end
    present(10'd116, 10'd50, 24'h654321);
    step();
    n_cmp++;
    if ({pix_out, hit_out} !== {24'h654321, 1'b0}) begin
      n_err++; $display("FAIL right_edge got pix=%h hit=%b want 654321 0", pix_out, hit_out);
    end
    $display("edges: transparent texel and bounding box checked");
  endtask

  task automatic test_shadow_commit();
    write_slot(2'd1, 10'd200, 10'd0, 1'b1, 1'b0);
    present(10'd207, 10'd1, 24'h00FF00);
    step();
    n_cmp++;
    if ({pix_out, hit_out} !== {24'h00FF00, 1'b0}) begin
      n_err++; $display("FAIL shadow_uncommitted got pix=%h hit=%b want 00FF00 0", pix_out, hit_out);
    end
    pulse_fs();
    present(10'd207, 10'd1, 24'h00FF00);
    n_cmp++;
    if (rom_addr !== 8'd23) begin
      n_err++; $display("FAIL shadow_addr got %0d want 23", rom_addr);
    end
    step();
    n_cmp++;
    if ({pix_out, hit_out, hit_idx} !== {24'hFF0000, 1'b1, 2'd1}) begin
      n_err++; $display("FAIL shadow_committed got pix=%h hit=%b idx=%0d want FF0000 1 1", pix_out, hit_out, hit_idx);
    end
    $display("shadow: slot1 visible only after frame_start");
  endtask

  task automatic test_priority_collision();
    write_slot(2'd0, 10'd10, 10'd10, 1'b1, 1'b0);
    write_slot(2'd2, 10'd10, 10'd10, 1'b1, 1'b0);
    pulse_fs();
    present(10'd17, 10'd11, 24'h0000FF);
    n_cmp++;
    if (rom_addr !== 8'd23) begin
      n_err++; $display("FAIL prio_addr got %0d want 23", rom_addr);
    end
    step();
    n_cmp++;
    if ({pix_out, hit_out, hit_idx} !== {24'hFF0000, 1'b1, 2'd0}) begin
      n_err++; $display("FAIL prio_pix got pix=%h hit=%b idx=%0d want FF0000 1 0", pix_out, hit_out, hit_idx);
    end
    n_cmp++;
    if (collision_out !== 1'b0) begin
      n_err++; $display("FAIL col_before_fs got %b want 0", collision_out);
    end
    pulse_fs();
    n_cmp++;
    if (collision_out !== 1'b1) begin
      n_err++; $display("FAIL col_set got %b want 1", collision_out);
    end
    present(10'd50, 10'd50, 24'h0);
    step();
    n_cmp++;
    if (collision_out !== 1'b1) begin
      n_err++; $display("FAIL col_hold got %b want 1", collision_out);
    end
    pulse_fs();
    n_cmp++;
    if (collision_out !== 1'b0) begin
      n_err++; $display("FAIL col_clear got %b want 0", collision_out);
    end
    // Overlap seen in the frame_start cycle itself belongs to the new frame
    pixel_x = 10'd17; pixel_y = 10'd11; pixel_valid = 1'b1;
    pulse_fs();
    pixel_valid = 1'b0;
    n_cmp++;
    if (collision_out !== 1'b0) begin
      n_err++; $display("FAIL col_newframe_now got %b want 0", collision_out);
    end
    step();
    pulse_fs();
    n_cmp++;
    if (collision_out !== 1'b1) begin
      n_err++; $display("FAIL col_newframe_next got %b want 1", collision_out);
    end
    $display("priority/collision: idx=0 shown, collision flag sequenced");
  endtask

  task automatic test_clip();
    write_slot(2'd3, 10'd1020, 10'd0, 1'b1, 1'b0);
    pulse_fs();
    present(10'd1023, 10'd5, 24'h0000FF);
    n_cmp++;
    if (rom_addr !== 8'd83) begin
      n_err++; $display("FAIL clip_addr got %0d want 83", rom_addr);
    end
    step();
    n_cmp++;
    if ({pix_out, hit_out, hit_idx} !== {24'hFF0000, 1'b1, 2'd3}) begin
      n_err++; $display("FAIL clip_in got pix=%h hit=%b idx=%0d want FF0000 1 3", pix_out, hit_out, hit_idx);
    end
    present(10'd0, 10'd5, 24'hABCDEF);
    step();
    n_cmp++;
    if ({pix_out, hit_out, hit_idx} !== {24'hABCDEF, 1'b0, 2'd0}) begin
      n_err++; $display("FAIL clip_nowrap got pix=%h hit=%b idx=%0d want ABCDEF 0 0", pix_out, hit_out, hit_idx);
    end
    $display("clip: slot3 at x=1020 clipped, no wrap");
  endtask

  task automatic test_back_to_back();
    // Write and commit in the same cycle: old position remains active
    write_slot(2'd0, 10'd400, 10'd400, 1'b1, 1'b1);
    present(10'd407, 10'd401, 24'h0F0F0F);
    step();
    n_cmp++;
    if ({pix_out, hit_out} !== {24'h0F0F0F, 1'b0}) begin
      n_err++; $display("FAIL samecycle_hidden got pix=%h hit=%b want 0F0F0F 0", pix_out, hit_out);
    end
    pulse_fs();
    // Consecutive pixels, one per clock
    pixel_valid = 1'b1; bg_color = 24'h0F0F0F;
    pixel_x = 10'd407; pixel_y = 10'd401;
    step();
    pixel_x = 10'd300; pixel_y = 10'd300;
    step();
    n_cmp++;
    if ({pix_out, hit_out, hit_idx} !== {24'hFF0000, 1'b1, 2'd0}) begin
      n_err++; $display("FAIL b2b_first got pix=%h hit=%b idx=%0d want FF0000 1 0", pix_out, hit_out, hit_idx);
    end
    step();
    n_cmp++;
    if ({pix_out, hit_out, pix_valid_out} !== {24'h0F0F0F, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL b2b_second got pix=%h hit=%b pvo=%b want 0F0F0F 0 1", pix_out, hit_out, pix_valid_out);
    end
    $display("back_to_back: same-cycle write deferred, streaming pixels");
  endtask

  task automatic test_reset_mid();
    pixel_x = 10'd407; pixel_y = 10'd401; pixel_valid = 1'b1;
    step(); step();
    n_cmp++;
    if ({pix_valid_out, hit_out} !== 2'b11) begin
      n_err++; $display("FAIL midreset_pre got pvo=%b hit=%b want 1 1", pix_valid_out, hit_out);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({rom_addr, pix_out, pix_valid_out, hit_out, hit_idx, collision_out} !== 38'd0) begin
      n_err++;
      $display("FAIL midreset_async got addr=%0d pix=%h pvo=%b hit=%b idx=%0d col=%b want all 0",
               rom_addr, pix_out, pix_valid_out, hit_out, hit_idx, collision_out);
    end
    step();
    reset = 1'b0;
    pixel_valid = 1'b0;
    present(10'd407, 10'd401, 24'h224466);
    step();
    n_cmp++;
    if ({pix_out, hit_out, pix_valid_out} !== {24'h224466, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL midreset_disabled got pix=%h hit=%b pvo=%b want 224466 0 1", pix_out, hit_out, pix_valid_out);
    end
    $display("reset_mid: async clear, sprites disabled afterwards");
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_transparent_and_edges();
    test_shadow_commit();
    test_priority_collision();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Shares the single combinational 16x16 sprite ROM (8-bit row-major address, 24-bit RGB data) among NUM_SPRITES on-screen objects.
- Sits between the VGA timing generator and the RGB output register. For each active pixel it selects the highest-priority sprite covering that pixel, drives the ROM address and composites the result over the background colour.
- Sprite positions are double-buffered and committed only at frame start, so the image never tears.
- Flags sprite bounding-box overlaps once per frame for game logic.

Parameters:
- NUM_SPRITES, 4, number of sprite slots; the lowest index has the highest priority.
- COORD_W, 10, pixel coordinate width.
- TRANSPARENT, 24'h000000, ROM colour treated as see-through.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_x  in  COORD_W  current pixel column from the VGA timing generator
- pixel_y  in  COORD_W  current pixel row
- pixel_valid  in  1  active-video qualifier
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- bg_color  in  24  background colour for the current pixel
- wr_en  in  1  write strobe for the shadow sprite registers
- wr_idx  in  2  sprite slot to write
- wr_x  in  COORD_W  new left edge
- wr_y  in  COORD_W  new top edge
- wr_enable  in  1  new visibility bit
- rom_addr  out  8  address to sprite ROM, registered
- rom_data  in  24  ROM output, combinational from rom_addr
- pix_out  out  24  composited pixel
- pix_valid_out  out  1  pixel_valid delayed by 2 cycles
- hit_out  out  1  an opaque sprite pixel was emitted
- hit_idx  out  2  index of the sprite shown; 0 when hit_out=0
- collision_out  out  1  overlap occurred in the previous frame

Behaviour:
- Reset (async, active-high): all shadow and active registers (x, y, enable) = 0. rom_addr, pix_out, pix_valid_out, hit_out, hit_idx, collision_out and the internal sticky flag = 0. Pipeline valids = 0.
- Shadow write (rising edge, wr_en=1): shadow[wr_idx] <= {wr_x, wr_y, wr_enable}. Active registers are not affected.
- Commit (frame_start=1): active <= shadow for all slots in that cycle. If wr_en and frame_start are high in the same cycle, the write lands in shadow only and commits at the next frame_start.
- Coverage test, per slot i: covered_i = en_i && pixel_valid && (pixel_x - x_i) in [0,15] && (pixel_y - y_i) in [0,15].
  - Compute the difference in COORD_W+1 bits and treat a negative result as not covered. There is no wrap-around.
  - A sprite with x_i > 2^COORD_W - 16 is clipped on the right edge, not wrapped to the left.
- Stage 1 (registered):
  - sel = lowest i with covered_i.
  - s1_hit = any covered_i; s1_idx = sel.
  - rom_addr <= {dy[3:0], dx[3:0]} of sel, i.e. dy*16+dx; rom_addr holds its previous value when s1_hit=0.
  - s1_bg <= bg_color; s1_valid <= pixel_valid.
- Stage 2 (registered):
  - opaque = s1_hit && (rom_data != TRANSPARENT).
  - pix_out <= opaque ? rom_data : s1_bg.
  - hit_out <= opaque; hit_idx <= opaque ? s1_idx : 0.
  - pix_valid_out <= s1_valid.
  - When s1_valid=0: pix_out <= 24'h000000 (blanking).
- Latency is exactly 2 clocks from pixel inputs to pix_out, with throughput one pixel per clock.
- There is one ROM port and no fall-through: a transparent texel of the selected sprite shows bg_color, never a lower-priority sprite.
- Collision:
  - overlap_now = (number of covered_i) >= 2.
  - When frame_start=0: sticky <= sticky | overlap_now.
  - When frame_start=1: collision_out <= sticky, and sticky <= overlap_now. The new frame wins.
  - collision_out holds until the next frame_start.
- Reset asserted mid-frame clears the pipeline immediately. Output resumes with the first pixel presented 2 cycles after deassertion, with all sprites disabled until a write followed by a frame_start.

Test Plan:
- Reset, write slot0 to (100,50) enabled, pulse frame_start, scan pixel (107,55) -> 2 cycles later rom_addr=8'd87, pix_out=24'hFF0000, hit_out=1, hit_idx=0.
- Slot0 active at (100,50), pixel (100,50) with bg_color=24'h0000FF -> rom_addr=8'd0, texel transparent, pix_out=24'h0000FF, hit_out=0.
- Write slot1 to (200,0) enabled without frame_start, scan (207,1) -> pix_out=bg_color; after frame_start the same pixel -> pix_out=24'hFF0000, hit_idx=1.
- Slots 0 and 2 both at (10,10), pixel (17,11) -> hit_idx=0, pix_out=24'hFF0000. At the next frame_start collision_out=1; after a frame with no overlap, the following frame_start sets collision_out=0.
- Slot3 at (1020,0), pixels (1023,5) and (0,5) -> first covered (addr=8'd83), second not covered, pix_out=bg_color. Also check (99,50) and (116,50) against slot0 at (100,50): both are not covered.
- Assert reset while pix_valid_out=1 -> all outputs 0 asynchronously. wr_en and frame_start in the same cycle -> the value is not visible until the second frame_start.
